// File: rtl/id_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : id_bus_arbiter
// Purpose  : Round-robin arbiter that shares one native-bus slave port among
//            N_M masters. It allows a single outstanding transaction, returns
//            slave read data only to the master that owns the bus, and aborts
//            a hung access with a timeout error.
// Ports    : clk, rst (async, active-low)
//            m_valid/m_address/m_wdata/m_wstrb : per-master request lanes
//            m_rdata/m_ready                   : per-master completion lanes
//            s_valid/s_address/s_wdata/s_wstrb : slave request
//            s_rdata/s_ready                   : slave response
//            grant       : one-hot current owner (0 in IDLE)
//            timeout_err : one-cycle pulse on an aborted transaction
// Revision : 1.0 - initial release
// ============================================================================
module id_bus_arbiter #(
    parameter int N_M     = 2,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 1,
    parameter int STRB_W  = 1,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_M-1:0]        m_valid,
    input  logic [N_M*ADDR_W-1:0] m_address,
    input  logic [N_M*DATA_W-1:0] m_wdata,
    input  logic [N_M*STRB_W-1:0] m_wstrb,
    output logic [N_M*DATA_W-1:0] m_rdata,
    output logic [N_M-1:0]        m_ready,
    output logic                  s_valid,
    output logic [ADDR_W-1:0]     s_address,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [STRB_W-1:0]     s_wstrb,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic                  s_ready,
    output logic [N_M-1:0]        grant,
    output logic                  timeout_err
);

    localparam int c_idx_w = (N_M > 1) ? $clog2(N_M) : 1;
    // One extra bit so ptr + k (k up to N_M) never overflows before the wrap.
    localparam int c_sum_w = c_idx_w + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_idx_w-1:0]   r_owner;
    logic [7:0]           r_cnt;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_err;
    logic [c_idx_w-1:0]   w_pick;
    logic                 w_any;
    logic                 w_timeout;

    // Round-robin search starting just after the last owner. Iterating k
    // downwards lets the nearest requester (smallest k) win.
    always_comb begin
        logic [c_sum_w-1:0] sum;
        w_pick = r_ptr;
        w_any  = 1'b0;
        sum    = '0;
        for (int k = N_M; k >= 1; k--) begin
            sum = {1'b0, r_ptr} + c_sum_w'(k);
            if (sum >= c_sum_w'(N_M)) begin
                sum = sum - c_sum_w'(N_M);
            end
            for (int i = 0; i < N_M; i++) begin
                if (sum == c_sum_w'(i) && m_valid[i]) begin
                    w_pick = c_idx_w'(i);
                    w_any  = 1'b1;
                end
            end
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == 8'(TIMEOUT - 1));

    // Next state and all outputs; everything is derived from registered
    // state so an asynchronous reset clears the outputs immediately.
    always_comb begin
        w_state_nxt = r_state;
        s_valid     = 1'b0;
        s_address   = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m_ready     = '0;
        m_rdata     = '0;
        grant       = '0;
        timeout_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                s_valid = 1'b1;
                for (int i = 0; i < N_M; i++) begin
                    if (r_owner == c_idx_w'(i)) begin
                        s_address = m_address[i*ADDR_W +: ADDR_W];
                        s_wdata   = m_wdata[i*DATA_W +: DATA_W];
                        s_wstrb   = m_wstrb[i*STRB_W +: STRB_W];
                        grant[i]  = 1'b1;
                    end
                end
                if (s_ready || w_timeout) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                timeout_err = r_err;
                for (int i = 0; i < N_M; i++) begin
                    if (r_owner == c_idx_w'(i)) begin
                        m_ready[i]                 = 1'b1;
                        m_rdata[i*DATA_W +: DATA_W] = r_rdata;
                        grant[i]                   = 1'b1;
                    end
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= c_idx_w'(N_M - 1);
            r_owner <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick;
                        r_cnt   <= '0;
                    end
                end
                ISSUE: begin
                    if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    // A completing slave takes precedence over an expiring timer.
                    if (s_ready) begin
                        r_rdata <= s_rdata;
                    end else if (w_timeout) begin
                        r_rdata <= '1;
                        r_err   <= 1'b1;
                    end
                end
                DONE: begin
                    r_ptr <= r_owner;
                    r_err <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_bus_arbiter
// Purpose  : Directed self-checking bench for id_bus_arbiter (2 masters,
//            TIMEOUT=4) with a small ID-block slave model of adjustable
//            latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  m_valid = '0;
    logic [1:0]  m_address = '0;
    logic [63:0] m_wdata = '0;
    logic [1:0]  m_wstrb = '0;
    logic [63:0] m_rdata;
    logic [1:0]  m_ready;
    logic        s_valid;
    logic [0:0]  s_address;
    logic [31:0] s_wdata;
    logic [0:0]  s_wstrb;
    logic [31:0] s_rdata;
    logic        s_ready;
    logic [1:0]  grant;
    logic        timeout_err;

    int   vectors     = 0;
    int   miscompares = 0;
    int   sl_cnt      = 0;
    int   sl_lat      = 1;
    logic sl_force    = 1'b0;
    logic auto_drop   = 1'b1;

    always #5 clk = ~clk;

    id_bus_arbiter #(
        .N_M     (2),
        .DATA_W  (32),
        .ADDR_W  (1),
        .STRB_W  (1),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_valid     (m_valid),
        .m_address   (m_address),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_rdata     (m_rdata),
        .m_ready     (m_ready),
        .s_valid     (s_valid),
        .s_address   (s_address),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_rdata     (s_rdata),
        .s_ready     (s_ready),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    // ID-block slave: ready after sl_lat cycles of continuous s_valid.
    always @(posedge clk) sl_cnt <= s_valid ? sl_cnt + 1 : 0;
    assign s_ready = sl_force | (s_valid && (sl_cnt == sl_lat));
    assign s_rdata = (s_wstrb != 1'b0) ? 32'h0 :
                     (s_address == 1'b0) ? 32'h0000_1234 : 32'hCAFE_0001;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic esv, input logic [1:0] egr,
                        input logic [1:0] emr, input logic [63:0] erd, input logic eerr,
                        input logic ea, input logic [31:0] ewd, input logic ews);
        logic [1:0] seen;
        @(negedge clk);
        chk({tag, ".s_valid"},   64'(s_valid),     64'(esv));
        chk({tag, ".grant"},     64'(grant),       64'(egr));
        chk({tag, ".m_ready"},   64'(m_ready),     64'(emr));
        chk({tag, ".m_rdata"},   m_rdata,          erd);
        chk({tag, ".tmo_err"},   64'(timeout_err), 64'(eerr));
        chk({tag, ".s_address"}, 64'(s_address),   64'(ea));
        chk({tag, ".s_wdata"},   64'(s_wdata),     64'(ewd));
        chk({tag, ".s_wstrb"},   64'(s_wstrb),     64'(ews));
        seen = m_ready;
        @(posedge clk);
        #1;
        if (auto_drop) m_valid = m_valid & ~seen;
    endtask

    task automatic idle_step(input string tag);
        step(tag, 1'b0, 2'b00, 2'b00, 64'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        m_valid  = '0;
        sl_force = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.s_valid", 64'(s_valid),     64'h0);
        chk("rst.grant",   64'(grant),       64'h0);
        chk("rst.m_ready", 64'(m_ready),     64'h0);
        chk("rst.m_rdata", m_rdata,          64'h0);
        chk("rst.tmo_err", 64'(timeout_err), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic found;

        // 1: single read by master 0
        do_reset();
        m_address = 2'b00; m_wdata = '0; m_wstrb = '0; sl_lat = 1;
        m_valid = 2'b01;
        idle_step("t1c0");
        step("t1c1", 1, 2'b01, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        step("t1c2", 1, 2'b01, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        step("t1c3", 0, 2'b01, 2'b01, 64'h0000_0000_0000_1234, 0, 0, 32'h0, 0);
        idle_step("t1c4");

        // 2: both request after reset; master 0 then master 1
        do_reset();
        m_valid = 2'b11;
        idle_step("t2c0");
        step("t2c1", 1, 2'b01, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        step("t2c2", 1, 2'b01, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        step("t2c3", 0, 2'b01, 2'b01, 64'h0000_0000_0000_1234, 0, 0, 32'h0, 0);
        idle_step("t2c4");
        step("t2c5", 1, 2'b10, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        step("t2c6", 1, 2'b10, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        step("t2c7", 0, 2'b10, 2'b10, 64'h0000_1234_0000_0000, 0, 0, 32'h0, 0);
        idle_step("t2c8");

        // 3: continuous requests from both -> strict alternation
        do_reset();
        auto_drop = 1'b0;
        m_valid = 2'b11;
        for (int t = 0; t < 8; t++) begin
            found = 1'b0;
            for (int w = 0; w < 12 && !found; w++) begin
                @(negedge clk);
                if (m_ready != 2'b00) found = 1'b1;
            end
            chk($sformatf("t3.done%0d", t), 64'(found), 64'h1);
            chk($sformatf("t3.grant%0d", t), 64'(grant), 64'(2'b01 << (t % 2)));
            chk($sformatf("t3.ready%0d", t), 64'(m_ready), 64'(2'b01 << (t % 2)));
            @(posedge clk);
            #1;
        end
        m_valid = 2'b00;
        auto_drop = 1'b1;

        // 4: timeout abort, then s_ready on the last allowed cycle
        do_reset();
        sl_lat = 255;
        m_valid = 2'b10;
        idle_step("t4c0");
        for (int c = 1; c <= 4; c++)
            step($sformatf("t4c%0d", c), 1, 2'b10, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        step("t4c5", 0, 2'b10, 2'b10, 64'hFFFF_FFFF_0000_0000, 1, 0, 32'h0, 0);
        idle_step("t4c6");
        sl_lat = 3;
        m_valid = 2'b10;
        idle_step("t4v0");
        for (int c = 1; c <= 4; c++)
            step($sformatf("t4v%0d", c), 1, 2'b10, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        step("t4v5", 0, 2'b10, 2'b10, 64'h0000_1234_0000_0000, 0, 0, 32'h0, 0);
        idle_step("t4v6");

        // 5: reset asserted in the middle of ISSUE
        do_reset();
        sl_lat = 1;
        m_valid = 2'b11;
        idle_step("t5c0");
        step("t5c1", 1, 2'b01, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        #2 rst = 1'b0;
        #1;
        chk("t5.rst_s_valid", 64'(s_valid), 64'h0);
        chk("t5.rst_grant",   64'(grant),   64'h0);
        chk("t5.rst_m_ready", 64'(m_ready), 64'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle_step("t5r0");
        step("t5r1", 1, 2'b01, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        step("t5r2", 1, 2'b01, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        step("t5r3", 0, 2'b01, 2'b01, 64'h0000_0000_0000_1234, 0, 0, 32'h0, 0);
        idle_step("t5r4");
        step("t5r5", 1, 2'b10, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        step("t5r6", 1, 2'b10, 2'b00, 64'h0, 0, 0, 32'h0, 0);
        step("t5r7", 0, 2'b10, 2'b10, 64'h0000_1234_0000_0000, 0, 0, 32'h0, 0);
        idle_step("t5r8");

        // 6: master 1 write; master 0 lanes hold different values
        do_reset();
        m_address = 2'b10;
        m_wdata   = 64'hA5A5_A5A5_5A5A_5A5A;
        m_wstrb   = 2'b10;
        m_valid   = 2'b10;
        idle_step("t6c0");
        step("t6c1", 1, 2'b10, 2'b00, 64'h0, 0, 1, 32'hA5A5_A5A5, 1);
        step("t6c2", 1, 2'b10, 2'b00, 64'h0, 0, 1, 32'hA5A5_A5A5, 1);
        step("t6c3", 0, 2'b10, 2'b10, 64'h0, 0, 0, 32'h0, 0);
        idle_step("t6c4");
        idle_step("t6c5");

        // Stale s_ready while IDLE must not complete anything
        sl_force = 1'b1;
        idle_step("st0");
        idle_step("st1");
        idle_step("st2");
        sl_force = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
